// File: rtl/RouterPkg.sv
// Router-wide shared types: node identifiers and the packet format carried between nodes.
package RouterPkg;

    localparam int NUM_NODES = 6;

    typedef enum logic [3:0] {
        NODE0 = 4'd0,
        NODE1 = 4'd1,
        NODE2 = 4'd2,
        NODE3 = 4'd3,
        NODE4 = 4'd4,
        NODE5 = 4'd5
    } node_t;

    typedef struct packed {
        node_t      dest;
        node_t      src;
        logic [7:0] payload;
    } pkt_t;

endpackage

// File: rtl/input_queue_pkg.sv
// Local types for input_queue: occupancy state encoding and the destination legality check.
package input_queue_pkg;
    import RouterPkg::*;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } q_state_t;

    function automatic logic dest_valid(input node_t d);
        return int'(d) < NUM_NODES;
    endfunction

endpackage

// File: rtl/input_queue_if.sv
// Link-side and routing-side handshake bundle for input_queue.
// Carries drop_count_out only when INPUT_QUEUE_DEST_CHECK_EN is defined.
interface input_queue_if #(parameter int DEPTH = 4);
    import RouterPkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    pkt_t          pkt_in;
    logic          pkt_valid_in;
    logic          pkt_ready_out;
    pkt_t          data_out;
    logic          data_ready_out;
    logic          data_routed_in;
    logic [CW-1:0] count_out;
`ifdef INPUT_QUEUE_DEST_CHECK_EN
    logic [7:0]    drop_count_out;
`endif

    modport master (
        output pkt_in, pkt_valid_in, data_routed_in,
        input  pkt_ready_out, data_out, data_ready_out, count_out
`ifdef INPUT_QUEUE_DEST_CHECK_EN
        , input drop_count_out
`endif
    );

    modport slave (
        input  pkt_in, pkt_valid_in, data_routed_in,
        output pkt_ready_out, data_out, data_ready_out, count_out
`ifdef INPUT_QUEUE_DEST_CHECK_EN
        , output drop_count_out
`endif
    );

endinterface

// File: rtl/input_queue_ram.sv
// Packet storage for input_queue: DEPTH entries, one synchronous write port, one asynchronous read port.
module queue_ram
    import RouterPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  pkt_t                     wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output pkt_t                     rdata
);

    pkt_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/input_queue.sv
// Packet input FIFO with EMPTY/ACTIVE/FULL occupancy FSM; storage lives in queue_ram.
// Optional INPUT_QUEUE_DEST_CHECK_EN drops packets with an unknown destination and counts them.
module input_queue
    import RouterPkg::*;
    import input_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic          clock,
    input logic          reset_n,
    input_queue_if.slave q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    q_state_t      state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    pkt_t          rd_data;
    logic          accept;
    logic          push;
    logic          pop;

    // Handshake status decodes from registered state only; no input reaches these outputs.
    assign q.pkt_ready_out  = (state != FULL);
    assign q.data_ready_out = (state != EMPTY);
    assign q.count_out      = count;
    assign q.data_out       = (state == EMPTY) ? '0 : rd_data;

    assign accept = q.pkt_valid_in && q.pkt_ready_out;
    assign pop    = q.data_routed_in && q.data_ready_out;

`ifdef INPUT_QUEUE_DEST_CHECK_EN
    logic       dest_ok;
    logic [7:0] drop_count;

    // A bad-destination packet still completes the handshake but is never written.
    assign dest_ok = dest_valid(q.pkt_in.dest);
    assign push    = accept && dest_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (accept && !dest_ok && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    assign q.drop_count_out = drop_count;
`else
    assign push = accept;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        state <= ACTIVE;
                        count <= CW'(1);
                    end
                end
                ACTIVE: begin
                    if (push && !pop) begin
                        count <= count + 1'b1;
                        if (count == CW'(DEPTH - 1)) begin
                            state <= FULL;
                        end
                    end else if (pop && !push) begin
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state <= EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        state <= ACTIVE;
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    count <= '0;
                end
            endcase
        end
    end

    queue_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (q.pkt_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_input_queue.sv
// Self-checking bench for input_queue: directed scenarios then random traffic against a queue model.
// Build with INPUT_QUEUE_DEST_CHECK_EN defined to exercise the destination drop path.
module tb_input_queue;
    import RouterPkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clock;
    logic reset_n;

    input_queue_if #(.DEPTH(DEPTH)) q_if ();

    input_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (q_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned tests = 0;
    int unsigned fails = 0;

    pkt_t        model [$];
    int unsigned model_drops = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d fails=%0d)", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic pkt_t mk_pkt(input logic [3:0] d, input logic [7:0] pl);
        pkt_t p;
        p.dest    = node_t'(d);
        p.src     = node_t'(4'($urandom_range(0, 5)));
        p.payload = pl;
        return p;
    endfunction

    task automatic check_all(input string tag);
        logic [CW-1:0] exp_cnt;
        logic          exp_drdy;
        logic          exp_prdy;
        pkt_t          exp_data;
        exp_cnt  = CW'(model.size());
        exp_drdy = (model.size() != 0);
        exp_prdy = (model.size() != DEPTH);
        exp_data = (model.size() != 0) ? model[0] : '0;

        tests++;
        assert (q_if.count_out === exp_cnt) else begin
            fails++;
            $error("FAIL %s count_out got %0d exp %0d", tag, q_if.count_out, exp_cnt);
        end
        tests++;
        assert (q_if.data_ready_out === exp_drdy) else begin
            fails++;
            $error("FAIL %s data_ready_out got %b exp %b", tag, q_if.data_ready_out, exp_drdy);
        end
        tests++;
        assert (q_if.pkt_ready_out === exp_prdy) else begin
            fails++;
            $error("FAIL %s pkt_ready_out got %b exp %b", tag, q_if.pkt_ready_out, exp_prdy);
        end
        tests++;
        assert (q_if.data_out === exp_data) else begin
            fails++;
            $error("FAIL %s data_out got %h exp %h", tag, q_if.data_out, exp_data);
        end
`ifdef INPUT_QUEUE_DEST_CHECK_EN
        tests++;
        assert (q_if.drop_count_out === 8'(model_drops)) else begin
            fails++;
            $error("FAIL %s drop_count_out got %0d exp %0d", tag, q_if.drop_count_out, model_drops);
        end
`endif
    endtask

    // One clock: drive at the falling edge, let the DUT take the rising edge, then update and check.
    task automatic step(input logic v, input pkt_t p, input logic r, input string tag);
        logic acc;
        logic stored;
        logic popped;
        @(negedge clock);
        q_if.pkt_valid_in   = v;
        q_if.pkt_in         = p;
        q_if.data_routed_in = r;
        acc    = v && (model.size() < DEPTH);
        popped = r && (model.size() > 0);
`ifdef INPUT_QUEUE_DEST_CHECK_EN
        stored = acc && (int'(p.dest) < NUM_NODES);
        if (acc && !stored && model_drops < 255) model_drops++;
`else
        stored = acc;
`endif
        @(posedge clock);
        #1;
        if (popped) void'(model.pop_front());
        if (stored) model.push_back(p);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        pkt_t p;
        logic v;
        logic r;

        q_if.pkt_in         = '0;
        q_if.pkt_valid_in   = 1'b0;
        q_if.data_routed_in = 1'b0;
        reset_n             = 1'b0;
        #1;
        check_all("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // First push into empty queue is visible only after the edge.
        step(1'b1, mk_pkt(4'd2, 8'hA1), 1'b0, "push_node2");
        tests++;
        assert (q_if.data_out.dest === NODE2) else begin
            fails++;
            $error("FAIL push_node2_dest got %0d exp %0d", q_if.data_out.dest, NODE2);
        end

        // Fill to DEPTH, then a fifth valid must be refused.
        step(1'b1, mk_pkt(4'd1, 8'hB2), 1'b0, "fill2");
        step(1'b1, mk_pkt(4'd3, 8'hC3), 1'b0, "fill3");
        step(1'b1, mk_pkt(4'd5, 8'hD4), 1'b0, "fill4");
        step(1'b1, mk_pkt(4'd0, 8'hE5), 1'b0, "overflow");
        tests++;
        assert (q_if.count_out === CW'(DEPTH)) else begin
            fails++;
            $error("FAIL full_count got %0d exp %0d", q_if.count_out, DEPTH);
        end

        // Drain in push order; routed while empty must be ignored.
        for (int unsigned i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");
        step(1'b0, '0, 1'b1, "routed_when_empty");

        // Hold occupancy at two with simultaneous push/pop so pointers wrap.
        step(1'b1, mk_pkt(4'd4, 8'h11), 1'b0, "pre_wrap1");
        step(1'b1, mk_pkt(4'd2, 8'h22), 1'b0, "pre_wrap2");
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1, mk_pkt(4'(i % 6), 8'(8'h30 + i)), 1'b1, "push_pop");
        end

        // Asynchronous reset with three entries and a push pending in the same cycle.
        step(1'b1, mk_pkt(4'd1, 8'h55), 1'b0, "pre_rst");
        @(negedge clock);
        q_if.pkt_valid_in   = 1'b1;
        q_if.pkt_in         = mk_pkt(4'd3, 8'h66);
        q_if.data_routed_in = 1'b1;
        #2;
        reset_n = 1'b0;
        model.delete();
        model_drops = 0;
        #1;
        check_all("async_reset");
        @(posedge clock);
        #1;
        check_all("held_in_reset");
        @(negedge clock);
        reset_n = 1'b1;
        q_if.pkt_valid_in   = 1'b0;
        q_if.data_routed_in = 1'b0;
        step(1'b1, mk_pkt(4'd4, 8'h77), 1'b0, "push_after_rst");
        tests++;
        assert (q_if.data_out.dest === NODE4) else begin
            fails++;
            $error("FAIL after_rst_dest got %0d exp %0d", q_if.data_out.dest, NODE4);
        end

`ifdef INPUT_QUEUE_DEST_CHECK_EN
        step(1'b1, mk_pkt(4'd9, 8'h99), 1'b0, "bad_dest");
        tests++;
        assert (q_if.drop_count_out === 8'd1) else begin
            fails++;
            $error("FAIL bad_dest_drops got %0d exp 1", q_if.drop_count_out);
        end
`endif

        // Random traffic with alternating fill-biased and drain-biased phases.
        for (int unsigned i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                v = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
`ifdef INPUT_QUEUE_DEST_CHECK_EN
            p = mk_pkt(4'($urandom_range(0, 15)), 8'($urandom));
`else
            p = mk_pkt(4'($urandom_range(0, 5)), 8'($urandom));
`endif
            step(v, p, r, "random");
        end
        idle("final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_queue.md
INPUT_QUEUE -- requirements
Module: input_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of packet entries; power of two, minimum 2.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port pkt_in, input, pkt_t, packet arriving from the link.
REQ-005 SHALL have port pkt_valid_in, input, 1, pkt_in is valid this cycle.
REQ-006 SHALL have port pkt_ready_out, output, 1, the queue can accept pkt_in this cycle.
REQ-007 SHALL have port data_out, output, pkt_t, head-of-queue packet presented to routing logic.
REQ-008 SHALL have port data_ready_out, output, 1, data_out holds a valid packet.
REQ-009 SHALL have port data_routed_in, input, 1, routing logic has consumed the head packet.
REQ-010 SHALL have port count_out, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-011 SHALL accept (push) a packet on a clock edge when pkt_valid_in && pkt_ready_out.
REQ-012 SHALL drive pkt_ready_out = (state != FULL), decoded from registered state only, with no combinational path from any input.
REQ-013 SHALL remove (pop) the head on a clock edge when data_routed_in && data_ready_out.
REQ-014 SHALL ignore data_routed_in when data_ready_out is low: no pointer or count change.
REQ-015 SHALL give one-cycle latency: a packet pushed into an empty queue at edge N appears on data_out with data_ready_out high after edge N, never in the same cycle.
REQ-016 SHALL hold data_out stable and data_ready_out high until the pop edge; packets leave in strict FIFO order.
REQ-017 SHALL implement states EMPTY, ACTIVE, FULL, with transitions:
- EMPTY -> ACTIVE on push.
- ACTIVE -> FULL on push without pop when count = DEPTH-1.
- ACTIVE -> EMPTY on pop without push when count = 1.
- FULL -> ACTIVE on pop.
- All other cases hold the current state.
REQ-018 SHALL, on simultaneous push and pop in ACTIVE, write the new tail, advance both pointers, and leave count and state unchanged.
REQ-019 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH without extra logic.
REQ-020 SHALL keep count_out in range 0..DEPTH at all times; count_out = DEPTH exactly when state = FULL, and 0 exactly when state = EMPTY.
REQ-021 SHALL drive data_out to '0 when the queue is empty.

Reset
REQ-022 SHALL, while reset_n is low, immediately set state = EMPTY, both pointers = 0, count_out = 0, data_ready_out = 0, pkt_ready_out = 1, and data_out = '0.
REQ-023 SHALL discard all stored packets when reset asserts mid-operation, including a packet being pushed or popped in that cycle; storage contents need not be cleared.
REQ-024 SHALL resume normal operation on the first rising clock edge after reset_n deasserts.

Configuration
REQ-025 SHALL, when macro INPUT_QUEUE_DEST_CHECK_EN is defined:
- drop any handshaken packet whose dest is not NODE0..NODE5 (it is not stored);
- provide output drop_count_out, 8 bits, which increments per dropped packet, saturates at 255, and resets to 0.
REQ-026 SHALL, when INPUT_QUEUE_DEST_CHECK_EN is undefined, store every handshaken packet and omit port drop_count_out.

Structure
REQ-027 SHALL take pkt_t, the node_t enumeration (NODE0..NODE5, 4-bit) and constant NUM_NODES = 6 from package RouterPkg; no local redefinition.
REQ-028 SHALL place packet storage in one sub-module queue_ram: a DEPTH x pkt_t register array with one synchronous write port and one asynchronous read port.
REQ-029 SHALL keep the state machine, pointers, count and the optional destination check inside input_queue.

Verification
REQ-030 SHALL cover reset, then push dest=NODE2 at edge 1 -> data_ready_out=1 and data_out.dest=NODE2 after edge 1, count_out=1.
REQ-031 SHALL cover DEPTH=4 with 4 pushes and no pop -> pkt_ready_out=0, state FULL; a 5th valid is ignored and count_out stays 4.
REQ-032 SHALL cover full queue with data_routed_in=1 for 4 cycles -> packets emerge in push order, then count_out=0, data_ready_out=0, and data_out=0.
REQ-033 SHALL cover count_out=2 with simultaneous push and pop for 6 cycles -> count_out stays 2, pointers wrap past 3, and order is preserved.
REQ-034 SHALL cover reset_n pulsed low while count_out=3 -> immediately count_out=0 and pkt_ready_out=1; a following push of dest=NODE4 is presented correctly.
REQ-035 SHALL cover, with INPUT_QUEUE_DEST_CHECK_EN defined, a push of dest=4'd9 -> not stored, count_out unchanged, drop_count_out=1.
